// File: rtl/mul_sched_pkg.sv
// Shared defaults, latency helper and bench test identifiers for the
// shared pipelined multiplier scheduler.
package mul_sched_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 16;
  localparam int DEFAULT_PIPELINE_DEPTH = 4;
  localparam int DEFAULT_REQUESTERS     = 4;

  // Issue-to-result cycles: the final stage is combinational into the output
  function automatic int latency(input int depth);
    return depth - 1;
  endfunction

  typedef enum logic [2:0] {
    TEST_RESET,
    TEST_SINGLE,
    TEST_ROUND_ROBIN,
    TEST_EXTREMES,
    TEST_BACKPRESSURE,
    TEST_STREAM,
    TEST_RESET_MID
  } test_id_e;

endpackage

// File: rtl/mul_rr_arbiter.sv
// Combinational round-robin arbiter: scans circularly starting one past
// the last granted requester and returns a one-hot grant plus its index.
module mul_rr_arbiter #(
  parameter int  REQUESTERS = 4,
  localparam int ID_W       = $clog2(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] req_i,
  input  logic [ID_W-1:0]       last_grant_i,
  output logic [REQUESTERS-1:0] grant_o,
  output logic [ID_W-1:0]       grant_idx_o
);

  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int off = 1; off <= REQUESTERS; off++) begin
      idx = ID_W'((int'(last_grant_i) + off) % REQUESTERS);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/pipelined_array_multiplier.sv
// Unsigned array multiplier split into PIPELINE_DEPTH partial-product stages;
// all but the last stage are registered, and everything holds when clk_en_i is low.
module pipelined_array_multiplier #(
  parameter int DATA_WIDTH     = 16,
  parameter int PIPELINE_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clk_en_i,
  input  logic                    data_valid_i,
  input  logic [DATA_WIDTH-1:0]   multiplicand_i,
  input  logic [DATA_WIDTH-1:0]   multiplier_i,
  output logic                    data_valid_o,
  output logic [2*DATA_WIDTH-1:0] product_o
);

  localparam int CW     = DATA_WIDTH / PIPELINE_DEPTH;
  localparam int STAGES = PIPELINE_DEPTH - 1;
  localparam int PW     = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] st_a   [PIPELINE_DEPTH];
  logic [DATA_WIDTH-1:0] st_b   [PIPELINE_DEPTH];
  logic [PW-1:0]         st_acc [PIPELINE_DEPTH];
  logic [PW-1:0]         st_sum [PIPELINE_DEPTH];

  logic [STAGES-1:0]     valid_q, valid_d;
  logic [DATA_WIDTH-1:0] a_q   [STAGES];
  logic [DATA_WIDTH-1:0] a_d   [STAGES];
  logic [DATA_WIDTH-1:0] b_q   [STAGES];
  logic [DATA_WIDTH-1:0] b_d   [STAGES];
  logic [PW-1:0]         acc_q [STAGES];
  logic [PW-1:0]         acc_d [STAGES];

  // Stage s adds multiplicand times the s-th CW-bit slice of the multiplier
  always_comb begin
    logic [PW-1:0] pp;
    pp        = '0;
    st_a[0]   = multiplicand_i;
    st_b[0]   = multiplier_i;
    st_acc[0] = '0;
    for (int s = 1; s < PIPELINE_DEPTH; s++) begin
      st_a[s]   = a_q[s-1];
      st_b[s]   = b_q[s-1];
      st_acc[s] = acc_q[s-1];
    end
    for (int s = 0; s < PIPELINE_DEPTH; s++) begin
      pp        = PW'(st_a[s]) * PW'(st_b[s][s*CW +: CW]);
      st_sum[s] = st_acc[s] + (pp << (s * CW));
    end
  end

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    if (clk_en_i) begin
      valid_d[0] = data_valid_i;
      for (int s = 1; s < STAGES; s++) begin
        valid_d[s] = valid_q[s-1];
      end
      for (int s = 0; s < STAGES; s++) begin
        a_d[s]   = st_a[s];
        b_d[s]   = st_b[s];
        acc_d[s] = st_sum[s];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        acc_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign data_valid_o = valid_q[STAGES-1];
  assign product_o    = st_sum[PIPELINE_DEPTH-1];

endmodule

// File: rtl/pipelined_multiplier_scheduler.sv
// Shares one pipelined multiplier among REQUESTERS clients with round-robin
// issue, an ID shift register aligned to the pipeline, and freeze on back-pressure.
module pipelined_multiplier_scheduler
  import mul_sched_pkg::*;
#(
  parameter int  DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int  PIPELINE_DEPTH = DEFAULT_PIPELINE_DEPTH,
  parameter int  REQUESTERS     = DEFAULT_REQUESTERS,
  localparam int LATENCY        = latency(PIPELINE_DEPTH),
  localparam int ID_W           = $clog2(REQUESTERS),
  localparam int CNT_W          = $clog2(LATENCY + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic [REQUESTERS-1:0]                req_valid_i,
  input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0] req_multiplicand_i,
  input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0] req_multiplier_i,
  output logic [REQUESTERS-1:0]                req_ready_o,
  output logic                                 result_valid_o,
  output logic [2*DATA_WIDTH-1:0]              result_o,
  output logic [ID_W-1:0]                      result_id_o,
  input  logic                                 result_ready_i,
  output logic [CNT_W-1:0]                     outstanding_o,
  output logic                                 busy_o
);

  logic                  freeze;
  logic                  issue;
  logic                  result_hs;
  logic [REQUESTERS-1:0] grant;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] a_hold_q, a_hold_d, b_hold_q, b_hold_d;
  logic [DATA_WIDTH-1:0] mul_a, mul_b;
  logic [ID_W-1:0]       id_sr_q [LATENCY];
  logic [ID_W-1:0]       id_sr_d [LATENCY];
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;

  assign freeze      = result_valid_o & ~result_ready_i;
  assign req_ready_o = grant & {REQUESTERS{~freeze & rst_n_i}};
  assign issue       = |(req_valid_i & req_ready_o);
  assign result_hs   = result_valid_o & result_ready_i;

  mul_rr_arbiter #(
    .REQUESTERS (REQUESTERS)
  ) u_arbiter (
    .req_i        (req_valid_i),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  // Idle cycles re-present the last operands so the datapath does not toggle
  always_comb begin
    mul_a        = a_hold_q;
    mul_b        = b_hold_q;
    last_grant_d = last_grant_q;
    if (issue) begin
      mul_a        = req_multiplicand_i[grant_idx];
      mul_b        = req_multiplier_i[grant_idx];
      last_grant_d = grant_idx;
    end
    a_hold_d = mul_a;
    b_hold_d = mul_b;
  end

  pipelined_array_multiplier #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PIPELINE_DEPTH (PIPELINE_DEPTH)
  ) u_multiplier (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .clk_en_i       (~freeze),
    .data_valid_i   (issue),
    .multiplicand_i (mul_a),
    .multiplier_i   (mul_b),
    .data_valid_o   (result_valid_o),
    .product_o      (result_o)
  );

  always_comb begin
    id_sr_d = id_sr_q;
    if (!freeze) begin
      id_sr_d[0] = issue ? grant_idx : '0;
      for (int i = 1; i < LATENCY; i++) begin
        id_sr_d[i] = id_sr_q[i-1];
      end
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !result_hs) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!issue && result_hs) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_grant_q  <= ID_W'(REQUESTERS - 1);
      a_hold_q      <= '0;
      b_hold_q      <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        id_sr_q[i] <= '0;
      end
    end else begin
      last_grant_q  <= last_grant_d;
      a_hold_q      <= a_hold_d;
      b_hold_q      <= b_hold_d;
      outstanding_q <= outstanding_d;
      id_sr_q       <= id_sr_d;
    end
  end

  assign result_id_o   = id_sr_q[LATENCY-1];
  assign outstanding_o = outstanding_q;
  assign busy_o        = (outstanding_q != '0);

  // The pipeline cannot hold more than LATENCY operations, nor return one never issued
  always @(posedge clk_i) begin
    if (rst_n_i) begin
      assert (!(issue && !result_hs && outstanding_q == CNT_W'(LATENCY)));
      assert (!(result_hs && !issue && outstanding_q == '0));
    end
  end

endmodule

// File: tb/tb_pipelined_multiplier_scheduler.sv
// Directed bench for pipelined_multiplier_scheduler: a round-robin/timing model
// plus a scoreboard queue of expected {id, product} checked at the result port.
module tb_pipelined_multiplier_scheduler;
  import mul_sched_pkg::*;

  localparam int DW  = DEFAULT_DATA_WIDTH;
  localparam int PD  = DEFAULT_PIPELINE_DEPTH;
  localparam int R   = DEFAULT_REQUESTERS;
  localparam int L   = latency(PD);
  localparam int IDW = $clog2(R);
  localparam int CNW = $clog2(L + 1);

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [R-1:0]              req_valid_i = '0;
  logic [R-1:0][DW-1:0]      req_multiplicand_i = '0;
  logic [R-1:0][DW-1:0]      req_multiplier_i = '0;
  logic [R-1:0]              req_ready_o;
  logic                      result_valid_o;
  logic [2*DW-1:0]           result_o;
  logic [IDW-1:0]            result_id_o;
  logic                      result_ready_i = 1'b1;
  logic [CNW-1:0]            outstanding_o;
  logic                      busy_o;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [2*DW-1:0] prod;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         last_m;
  int         out_m;
  logic [L-1:0] vpipe_m;
  logic [DW-1:0] a_m [R];
  logic [DW-1:0] b_m [R];
  test_id_e   cur_test;

  pipelined_multiplier_scheduler #(
    .DATA_WIDTH     (DW),
    .PIPELINE_DEPTH (PD),
    .REQUESTERS     (R)
  ) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .req_valid_i        (req_valid_i),
    .req_multiplicand_i (req_multiplicand_i),
    .req_multiplier_i   (req_multiplier_i),
    .req_ready_o        (req_ready_o),
    .result_valid_o     (result_valid_o),
    .result_o           (result_o),
    .result_id_o        (result_id_o),
    .result_ready_i     (result_ready_i),
    .outstanding_o      (outstanding_o),
    .busy_o             (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no end of test, expected end before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s/%s: observed 0x%0h expected 0x%0h", cur_test.name(), tag, obs, expv);
    end
  endtask

  task automatic resetModel();
    exp_q.delete();
    vpipe_m = '0;
    out_m   = 0;
    last_m  = R - 1;
  endtask

  task automatic applyStimulus(input logic [R-1:0] valid, input logic ready);
    for (int k = 0; k < R; k++) begin
      req_multiplicand_i[k] = a_m[k];
      req_multiplier_i[k]   = b_m[k];
    end
    req_valid_i    = valid;
    result_ready_i = ready;
  endtask

  // Compare one cycle of DUT outputs with the model, then advance the model and clock
  task automatic checkOutput();
    logic [R-1:0] exp_grant;
    logic         exp_valid;
    logic         freeze_m;
    logic         hs_m;
    int           idx;
    int           gidx;
    exp_t         e;
    #1;
    exp_valid = vpipe_m[L-1];
    freeze_m  = exp_valid & ~result_ready_i;
    exp_grant = '0;
    gidx      = 0;
    if (rst_n && !freeze_m) begin
      for (int off = 1; off <= R; off++) begin
        idx = (last_m + off) % R;
        if (req_valid_i[idx]) begin
          exp_grant[idx] = 1'b1;
          gidx = idx;
          break;
        end
      end
    end
    chk("result_valid", 64'(result_valid_o), 64'(exp_valid));
    chk("req_ready", 64'(req_ready_o), 64'(exp_grant));
    chk("outstanding", 64'(outstanding_o), 64'(out_m));
    chk("busy", 64'(busy_o), 64'(out_m != 0));
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(1));
      end else begin
        e = exp_q[0];
        chk("result", 64'(result_o), 64'(e.prod));
        chk("result_id", 64'(result_id_o), 64'(e.id));
      end
    end
    hs_m = exp_valid & result_ready_i;
    if (hs_m && exp_q.size() > 0) void'(exp_q.pop_front());
    if (rst_n && !freeze_m) begin
      vpipe_m = {vpipe_m[L-2:0], |exp_grant};
      if (|exp_grant) begin
        e.id   = IDW'(gidx);
        e.prod = {{DW{1'b0}}, a_m[gidx]} * {{DW{1'b0}}, b_m[gidx]};
        exp_q.push_back(e);
        last_m = gidx;
      end
    end
    out_m = out_m + int'(|exp_grant) - int'(hs_m);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset applied mid-cycle, away from any clock edge
  task automatic assertReset();
    rst_n = 1'b0;
    resetModel();
    #1;
    chk("rst_result_valid", 64'(result_valid_o), 64'(0));
    chk("rst_outstanding", 64'(outstanding_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_req_ready", 64'(req_ready_o), 64'(0));
    chk("rst_result", 64'(result_o), 64'(0));
    chk("rst_result_id", 64'(result_id_o), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    applyStimulus('0, 1'b1);
    for (int i = 0; i < 20 && (exp_q.size() > 0 || out_m > 0); i++) checkOutput();
    checkOutput();
    chk("drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    for (int k = 0; k < R; k++) begin
      a_m[k] = '0;
      b_m[k] = '0;
    end
    resetModel();
    cur_test = TEST_RESET;
    applyStimulus('0, 1'b1);
    @(negedge clk);
    assertReset();

    cur_test = TEST_SINGLE;
    a_m[1] = 16'd3;
    b_m[1] = 16'd5;
    applyStimulus(4'b0010, 1'b1);
    checkOutput();
    applyStimulus('0, 1'b1);
    repeat (L + 1) checkOutput();
    chk("single_drained", 64'(exp_q.size()), 64'(0));

    cur_test = TEST_ROUND_ROBIN;
    assertReset();
    for (int k = 0; k < R; k++) begin
      a_m[k] = DW'(k + 1);
      b_m[k] = DW'(k + 1);
    end
    applyStimulus('1, 1'b1);
    repeat (R + 4) checkOutput();
    drain();

    cur_test = TEST_EXTREMES;
    a_m[0] = 16'hFFFF;
    b_m[0] = 16'hFFFF;
    applyStimulus(4'b0001, 1'b1);
    checkOutput();
    a_m[0] = 16'h0000;
    b_m[0] = 16'h1234;
    applyStimulus(4'b0001, 1'b1);
    checkOutput();
    applyStimulus('0, 1'b1);
    repeat (L - 2) checkOutput();
    #1;
    chk("extreme_max", 64'(result_o), 64'(32'hFFFE0001));
    @(negedge clk);
    #1;
    chk("extreme_zero", 64'(result_o), 64'(0));
    @(negedge clk);
    resetModel();
    assertReset();

    cur_test = TEST_BACKPRESSURE;
    for (int k = 0; k < R; k++) begin
      a_m[k] = DW'(k + 7);
      b_m[k] = DW'(100 + k);
    end
    applyStimulus('1, 1'b1);
    repeat (L) checkOutput();
    applyStimulus('1, 1'b0);
    repeat (2) checkOutput();
    drain();

    cur_test = TEST_STREAM;
    for (int k = 0; k < R; k++) begin
      a_m[k] = DW'(16'h0100 * (k + 1) + 16'h0033);
      b_m[k] = DW'(16'hF00F - k);
    end
    applyStimulus('1, 1'b1);
    repeat (10) checkOutput();
    drain();

    cur_test = TEST_RESET_MID;
    applyStimulus('1, 1'b1);
    repeat (2) checkOutput();
    assertReset();
    applyStimulus('1, 1'b1);
    checkOutput();
    applyStimulus('0, 1'b1);
    repeat (L + 3) checkOutput();
    chk("reset_mid_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_multiplier_scheduler.md
# pipelined_multiplier_scheduler

Shares one internal `pipelined_array_multiplier` among `REQUESTERS` clients. Uses round-robin arbitration with valid/ready handshakes. Tags each issued operation with its requester ID, which travels through a shift register aligned with the multiplier pipeline. Returns results in order on a single tagged output channel, and freezes the whole pipeline through the multiplier clock enable when the consumer back-pressures.

## Interface
Parameters:
- `DATA_WIDTH`, 16, operand width; power of 2.
- `PIPELINE_DEPTH`, 4, multiplier stages; ≥2, divides `DATA_WIDTH`.
- `REQUESTERS`, 4, number of clients; ≥2.

Ports:
- `clk_i`, in, 1, single clock.
- `rst_n_i`, in, 1, reset; asynchronous, active-low.
- `req_valid_i`, in, `REQUESTERS`, per-client request valid.
- `req_multiplicand_i`, in, `REQUESTERS`×`DATA_WIDTH`, per-client multiplicand.
- `req_multiplier_i`, in, `REQUESTERS`×`DATA_WIDTH`, per-client multiplier.
- `req_ready_o`, out, `REQUESTERS`, one-hot or zero grant.
- `result_valid_o`, out, 1, product available.
- `result_o`, out, 2·`DATA_WIDTH`, unsigned product.
- `result_id_o`, out, `$clog2(REQUESTERS)`, originating client.
- `result_ready_i`, in, 1, consumer accepts result.
- `outstanding_o`, out, `$clog2(LATENCY+1)`, operations in flight.
- `busy_o`, out, 1, `outstanding_o != 0`.

## Operation
- `LATENCY = PIPELINE_DEPTH - 1`.
- `freeze = result_valid_o & ~result_ready_i`.
- Multiplier `clk_en_i = ~freeze`.
  - The ID shift register and the issue logic use the same enable.
- Grant (combinational):
  - Pick the first requester with `req_valid_i` set, scanning circularly from `last_grant+1`.
  - `req_ready_o[k] = grant[k] & ~freeze & rst_n_i`.
- Issue:
  - Fires when `req_valid_i[k] & req_ready_o[k]`.
  - Muxes client k's operands into the multiplier with `data_valid_i=1`, pushes ID k, and sets `last_grant <= k`.
  - With no issue, multiplier `data_valid_i=0` and operands are held at the last value.
- Requesters hold operands stable while valid and not yet granted; dropping valid before grant is legal (request withdrawn).
- `last_grant` updates only on an issue; it is not moved by idle cycles or freeze.
- Results:
  - `result_valid_o` is the multiplier `data_valid_o`.
  - `result_o` is `product_o`.
  - `result_id_o` is the ID shift register tail.
  - Results leave in issue order.
- Outstanding counter:
  - +1 on issue, −1 on result handshake, unchanged when both or neither occur.
  - Never exceeds `LATENCY`.
  - Overflow or underflow is a design error; flag it with an assertion.
- Reset values:
  - `result_valid_o=0`, `result_o=0`, `result_id_o=0`, `req_ready_o=0`, `outstanding_o=0`, `busy_o=0`.
  - `last_grant=REQUESTERS-1`, so client 0 has first priority.
- Reset mid-operation: all in-flight operations are discarded silently, with no partial results.

## Timing
- Issue in cycle t gives `result_valid_o` in cycle t+`LATENCY` when there is no freeze; each frozen cycle adds exactly one cycle.
- Throughput is one issue per cycle while unfrozen.
- A continuously valid client is granted at least once every `REQUESTERS` issues.
- During freeze:
  - All pipeline state holds and `req_ready_o=0`.
  - `result_*` stays stable until accepted.
- Result accepted in the same cycle as an issue: both complete, and `outstanding_o` is unchanged.
- `result_ready_i` is allowed high with `result_valid_o` low; this has no effect.
- Reset assertion clears all flops immediately (async). The first grant is possible in the first cycle after deassertion.

## Structure
- Package `mul_sched_pkg`:
  - Default parameter values.
  - `function latency(depth)`.
  - `typedef enum` for the test IDs used by the bench.
- Sub-module `mul_rr_arbiter`:
  - Inputs: request vector, `last_grant`.
  - Outputs: one-hot grant, encoded index.
  - Purely combinational and parameterised by `REQUESTERS`.
- Top-level contents:
  - Instantiates `pipelined_array_multiplier` with `DATA_WIDTH` and `PIPELINE_DEPTH`.
  - Contains the operand mux, the ID shift register (`LATENCY` entries), the `last_grant` flop and the outstanding counter.

## Test plan
Defaults: `DATA_WIDTH=16`, `PIPELINE_DEPTH=4`, `REQUESTERS=4`.
- Client 1 requests 3×5, `result_ready_i=1` → `req_ready_o=4'b0010`; 3 cycles later `result_valid_o=1`, `result_o=15`, `result_id_o=1`.
- All four clients valid continuously, client k sends (k+1)×(k+1) → grants 0,1,2,3,0 on consecutive cycles; results 1,4,9,16,1 with IDs 0,1,2,3,0 one per cycle.
- 0xFFFF×0xFFFF, then 0×0x1234 → results 0xFFFE0001, then 0.
- Backpressure: `result_ready_i` low for 2 cycles with 3 in flight → `result_o` and `result_id_o` held, `req_ready_o=0`, `outstanding_o=3`; after release, all 3 results arrive in order with no loss or duplicates.
- Issue and accept in the same cycle while streaming → `outstanding_o` stays at 3; `busy_o` drops one cycle after the last result is accepted.
- Reset with 2 in flight → `result_valid_o=0` and `outstanding_o=0` asynchronously; after release no stale result appears, and the first grant goes to client 0 when all clients are valid.
